// File: rtl/adder_serial_nbit.sv
// Multi-cycle adder: latches two NUM_BITS operands plus carry-in, then adds
// DIGIT_W bits per clock, rippling the carry through a flop.
module adder_serial_nbit #(
  parameter int NUM_BITS = 8,
  parameter int DIGIT_W  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int NUM_DIGITS = NUM_BITS / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if ((NUM_BITS % DIGIT_W) != 0 || NUM_BITS < 2) begin : g_bad_params
    $error("adder_serial_nbit: NUM_BITS must be >= 2 and a multiple of DIGIT_W");
  end

  typedef enum logic {IDLE, ADD} state_t;

  state_t              state, state_next;
  logic [NUM_BITS-1:0] a_reg, b_reg;
  logic                carry, cin_reg;
  logic [CNT_W-1:0]    cnt;
  logic                accept, last, msb_carry_in;
  logic [DIGIT_W-1:0]  a_dig, b_dig;
  logic [DIGIT_W:0]    dig_sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (cnt == CNT_W'(NUM_DIGITS - 1));
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = ADD;
      end
      ADD: if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
  always_comb begin
    a_dig        = a_reg[int'(cnt) * DIGIT_W +: DIGIT_W];
    b_dig        = b_reg[int'(cnt) * DIGIT_W +: DIGIT_W];
    dig_sum      = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, carry};
    msb_carry_in = a_dig[DIGIT_W-1] ^ b_dig[DIGIT_W-1] ^ dig_sum[DIGIT_W-1];
  end

  assign busy = (state == ADD);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      cin_reg   <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        carry   <= carry_in;
        cin_reg <= carry_in;
        cnt     <= '0;
        sum     <= '0;
      end else if (state == ADD) begin
        sum[int'(cnt) * DIGIT_W +: DIGIT_W] <= dig_sum[DIGIT_W-1:0];
        carry <= dig_sum[DIGIT_W];
        cnt   <= cnt + 1'b1;
        if (last) begin
          carry_out <= dig_sum[DIGIT_W];
          overflow  <= msb_carry_in ^ dig_sum[DIGIT_W];
          done      <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      assert (!$isunknown(a)) else $error("adder_serial_nbit: port a has X/Z at start");
      assert (!$isunknown(b)) else $error("adder_serial_nbit: port b has X/Z at start");
      assert (!$isunknown(carry_in))
        else $error("adder_serial_nbit: port carry_in has X/Z at start");
    end
    if (!rst && done) begin
      assert ({carry_out, sum} ==
              ({1'b0, a_reg} + {1'b0, b_reg} + {{NUM_BITS{1'b0}}, cin_reg}))
        else $error("adder_serial_nbit: result disagrees with a + b + carry_in");
    end
  end

endmodule
